// File: rtl/parking_slot_manager.sv
// Slot allocation sequencer for the parking occupancy bitmap: arbitrates entrance
// and exit gate requests, hands out the lowest free slot and validates releases.
//
// state   | meaning
// IDLE    | waiting for an eligible request; alternates on ties
// ENTRY   | allocate lowest free slot, pulse entry_ack
// EXIT    | validate exit_location, clear slot or pulse exit_error
// RELEASE | wait for the served request to drop
module parking_slot_manager #(
  parameter int N_SLOTS = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic [N_SLOTS-1:0] exit_location,
  output logic               entry_ack,
  output logic [N_SLOTS-1:0] park_location,
  output logic               exit_ack,
  output logic               exit_error,
  output logic [N_SLOTS-1:0] parking_capacity,
  output logic [CNT_W-1:0]   free_count,
  output logic               full
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_EXIT, S_RELEASE} state_t;

  localparam logic [N_SLOTS-1:0] ONE = N_SLOTS'(1);

  state_t             state, state_nxt;
  logic               last_exit, last_exit_nxt;  // 1: the last request served was an exit
  logic [N_SLOTS-1:0] cap_nxt, loc_nxt, free_slot;
  logic               entry_ack_nxt, exit_ack_nxt, exit_error_nxt;
  logic               entry_ok, exit_valid, found;
  logic [CNT_W-1:0]   occupied;

  assign full       = &parking_capacity;
  assign entry_ok   = entry_req && !full;
  assign exit_valid = (exit_location != '0) &&
                      ((exit_location & (exit_location - ONE)) == '0) &&
                      ((exit_location & parking_capacity) != '0);

  always_comb begin
    free_slot = '0;
    found     = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!found && !parking_capacity[i]) begin
        free_slot[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    occupied = '0;
    for (int i = 0; i < N_SLOTS; i++) occupied = occupied + CNT_W'(parking_capacity[i]);
    free_count = CNT_W'(N_SLOTS) - occupied;
  end

  always_comb begin
    state_nxt      = state;
    last_exit_nxt  = last_exit;
    cap_nxt        = parking_capacity;
    loc_nxt        = park_location;
    entry_ack_nxt  = 1'b0;
    exit_ack_nxt   = 1'b0;
    exit_error_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (exit_req && (!entry_ok || !last_exit)) begin
          state_nxt     = S_EXIT;
          last_exit_nxt = 1'b1;
        end else if (entry_ok) begin
          state_nxt     = S_ENTRY;
          last_exit_nxt = 1'b0;
        end
      end
      S_ENTRY: begin
        loc_nxt       = free_slot;
        cap_nxt       = parking_capacity | free_slot;
        entry_ack_nxt = 1'b1;
        state_nxt     = S_RELEASE;
      end
      S_EXIT: begin
        if (exit_valid) begin
          cap_nxt      = parking_capacity & ~exit_location;
          exit_ack_nxt = 1'b1;
        end else begin
          exit_error_nxt = 1'b1;
        end
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (last_exit ? !exit_req : !entry_req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      last_exit        <= 1'b1;
      parking_capacity <= '0;
      park_location    <= '0;
      entry_ack        <= 1'b0;
      exit_ack         <= 1'b0;
      exit_error       <= 1'b0;
    end else begin
      state            <= state_nxt;
      last_exit        <= last_exit_nxt;
      parking_capacity <= cap_nxt;
      park_location    <= loc_nxt;
      entry_ack        <= entry_ack_nxt;
      exit_ack         <= exit_ack_nxt;
      exit_error       <= exit_error_nxt;
    end
  end

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed bench for parking_slot_manager: allocation order, full handling,
// arbitration ties, exit validation and mid-transaction reset.
module tb_parking_slot_manager;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       entry_req, exit_req;
  logic [7:0] exit_location;
  logic       entry_ack, exit_ack, exit_error, full;
  logic [7:0] park_location, parking_capacity;
  logic [3:0] free_count;

  int total = 0;
  int bad   = 0;

  parking_slot_manager #(.N_SLOTS(8), .CNT_W(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .entry_req        (entry_req),
    .exit_req         (exit_req),
    .exit_location    (exit_location),
    .entry_ack        (entry_ack),
    .park_location    (park_location),
    .exit_ack         (exit_ack),
    .exit_error       (exit_error),
    .parking_capacity (parking_capacity),
    .free_count       (free_count),
    .full             (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_location = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Raises entry_req (if not already high), waits for the ack and checks the grant.
  task automatic do_entry(input logic [7:0] exp_loc, input logic [7:0] exp_cap, input bit chk_lat);
    int n = 0;
    bit seen = 0;
    entry_req = 1'b1;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (entry_ack || exit_ack || exit_error) seen = 1;
    end
    chk("entry_ack_seen", entry_ack, 1);
    chk("entry_no_exit_resp", {exit_ack, exit_error}, 0);
    if (chk_lat) chk("entry_latency", n, 2);
    chk("park_location", park_location, exp_loc);
    chk("capacity_after_entry", parking_capacity, exp_cap);
    entry_req = 1'b0;
    @(negedge clk);
    chk("entry_ack_one_cycle", entry_ack, 0);
  endtask

  task automatic do_exit(input logic [7:0] loc, input bit exp_ok, input logic [7:0] exp_cap);
    int n = 0;
    bit seen = 0;
    exit_location = loc;
    exit_req = 1'b1;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (entry_ack || exit_ack || exit_error) seen = 1;
    end
    chk("exit_resp_seen", seen, 1);
    chk("exit_ack", exit_ack, exp_ok);
    chk("exit_error", exit_error, !exp_ok);
    chk("exit_no_entry_ack", entry_ack, 0);
    chk("capacity_after_exit", parking_capacity, exp_cap);
    exit_req = 1'b0;
    @(negedge clk);
    chk("exit_resp_one_cycle", {exit_ack, exit_error}, 0);
  endtask

  initial begin
    int acks;
    logic [7:0] loc;
    logic [7:0] cap;

    // reset state
    apply_reset();
    chk("rst_capacity", parking_capacity, 8'h00);
    chk("rst_location", park_location, 8'h00);
    chk("rst_free_count", free_count, 8);
    chk("rst_full", full, 0);
    chk("rst_resp", {entry_ack, exit_ack, exit_error}, 0);

    // T1 first entry
    do_entry(8'h01, 8'h01, 1);
    chk("t1_free_count", free_count, 7);

    // T2 fill the lot
    loc = 8'h01; cap = 8'h01;
    for (int i = 1; i < 8; i++) begin
      loc = loc << 1;
      cap = cap | loc;
      do_entry(loc, cap, 1);
    end
    chk("t2_full", full, 1);
    chk("t2_free_count", free_count, 0);
    entry_req = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (entry_ack) acks++;
    end
    chk("t2_no_ack_when_full", acks, 0);

    // T3 exit while full, then pending entry takes the freed slot
    do_exit(8'h10, 1, 8'hEF);
    chk("t3_free_count", free_count, 1);
    do_entry(8'h10, 8'hFF, 0);
    chk("t3_full", full, 1);

    // T4 simultaneous requests after an exit was served last
    apply_reset();
    do_entry(8'h01, 8'h01, 1);
    do_entry(8'h02, 8'h03, 1);
    do_entry(8'h04, 8'h07, 1);
    do_exit(8'h04, 1, 8'h03);
    exit_location = 8'h01;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    do_entry(8'h04, 8'h07, 1);
    do_exit(8'h01, 1, 8'h06);
    chk("t4_free_count", free_count, 6);

    // T5 rejected exits leave the bitmap alone
    do_exit(8'h20, 0, 8'h06);
    do_exit(8'h03, 0, 8'h06);
    do_exit(8'h00, 0, 8'h06);
    do_exit(8'h80, 0, 8'h06);
    chk("t5_free_count", free_count, 6);

    // T6 reset while in ENTRY
    entry_req = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_ack_yet", entry_ack, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_capacity", parking_capacity, 8'h00);
    chk("t6_free_count", free_count, 8);
    chk("t6_location", park_location, 8'h00);
    entry_req = 1'b0;
    acks = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (entry_ack || exit_ack || exit_error) acks++;
    end
    chk("t6_no_resp_after_reset", acks, 0);
    chk("t6_capacity_stays", parking_capacity, 8'h00);
    do_entry(8'h01, 8'h01, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
